// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display blocks: default 640x480 timing,
// mode encoding, the per-pixel flag bundle and small timing helpers.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_BITMAP = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_BORDER = 2'd2,
        MODE_BLACK  = 2'd3
    } mode_e;

    // Everything the output stage needs to know about one pixel, carried
    // alongside the memory read so it lines up with mem_data.
    typedef struct packed {
        logic       active;
        logic       in_image;
        logic       hsync_on;
        logic       vsync_on;
        logic       sof;
        mode_e      mode;
        logic [2:0] bar;
    } pix_flags_t;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic img_hit(int x, int y, int w_log2, int h_log2, int scale_log2);
        return (((x >> scale_log2) >> w_log2) == 0) && (((y >> scale_log2) >> h_log2) == 0);
    endfunction

endpackage

// File: rtl/vga_bitmap_scanout_if.sv
// Read port of the external synchronous bitmap memory.
interface vga_bitmap_scanout_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 9
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_addr, input  mem_data);
    modport slave  (input  mem_addr, output mem_data);
endinterface

// File: rtl/vga_bitmap_scanout_timing.sv
// Free-running raster counters with active/sync/start-of-frame flags.
// The next-state counts are exported so callers can pre-register addresses.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic [HW-1:0] hcount_nxt,
    output logic [VW-1:0] vcount_nxt,
    output logic          active,
    output logic          hsync_on,
    output logic          vsync_on,
    output logic          sof
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (int'(hcount_q) == H_TOTAL - 1) begin
            hcount_d = '0;
            vcount_d = (int'(vcount_q) == V_TOTAL - 1) ? '0 : vcount_q + VW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign hcount_nxt = hcount_d;
    assign vcount_nxt = vcount_d;
    assign active     = (int'(hcount_q) < H_ACTIVE) && (int'(vcount_q) < V_ACTIVE);
    assign hsync_on   = (int'(hcount_q) >= H_ACTIVE + H_FP) &&
                        (int'(hcount_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign vsync_on   = (int'(vcount_q) >= V_ACTIVE + V_FP) &&
                        (int'(vcount_q) <  V_ACTIVE + V_FP + V_SYNC);
    assign sof        = (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: rtl/vga_bitmap_scanout.sv
// VGA scan-out: raster timing, bitmap read addressing and a pixel mux whose
// colour, syncs and frame strobe all reach the pins RD_LATENCY+1 clocks after the counters.
module vga_bitmap_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int BPC        = 3,
    parameter int IMG_W_LOG2 = 8,
    parameter int IMG_H_LOG2 = 8,
    parameter int SCALE_LOG2 = 0,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [3*BPC-1:0]     border_rgb,
    vga_bitmap_scanout_if.master mem,
    output logic [BPC-1:0]       vga_r,
    output logic [BPC-1:0]       vga_g,
    output logic [BPC-1:0]       vga_b,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 frame_start
);
    localparam int HW    = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW    = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int AW    = IMG_H_LOG2 + IMG_W_LOG2;
    localparam int CW    = 3 * BPC;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BPW   = $clog2(BAR_W + 1);

    logic [HW-1:0] hcount, hcount_nxt;
    logic [VW-1:0] vcount, vcount_nxt;
    logic          active, hsync_on, vsync_on, sof;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .reset(reset),
        .hcount(hcount), .vcount(vcount),
        .hcount_nxt(hcount_nxt), .vcount_nxt(vcount_nxt),
        .active(active), .hsync_on(hsync_on), .vsync_on(vsync_on), .sof(sof)
    );

    logic [31:0]                  x_nxt, y_nxt;
    logic                         addr_hit;
    logic [AW-1:0]                mem_addr_q, mem_addr_d;
    logic [BPW-1:0]               bar_px_q, bar_px_d;
    logic [2:0]                   bar_idx_q, bar_idx_d;
    mode_e                        mode_q, mode_d;
    pix_flags_t [RD_LATENCY-1:0]  pipe_q, pipe_d;
    pix_flags_t                   tail;
    logic [CW-1:0]                rgb_q, rgb_d;
    logic                         hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

    // Address is built from the counters' next value so that the registered
    // mem_addr lines up with the current hcount/vcount.
    always_comb begin
        x_nxt      = 32'(hcount_nxt) >> SCALE_LOG2;
        y_nxt      = 32'(vcount_nxt) >> SCALE_LOG2;
        addr_hit   = ((x_nxt >> IMG_W_LOG2) == 32'd0) && ((y_nxt >> IMG_H_LOG2) == 32'd0);
        mem_addr_d = addr_hit ? {y_nxt[IMG_H_LOG2-1:0], x_nxt[IMG_W_LOG2-1:0]} : '0;
    end

    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (hcount_nxt == '0) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (active) begin
            if (int'(bar_px_q) == BAR_W - 1) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + BPW'(1);
            end
        end
    end

    // Pixel (0,0) already uses the freshly sampled mode.
    always_comb begin
        mode_d = sof ? mode_e'(mode) : mode_q;
        pipe_d = pipe_q;
        pipe_d[0].active   = active;
        pipe_d[0].in_image = img_hit(int'(hcount), int'(vcount), IMG_W_LOG2, IMG_H_LOG2, SCALE_LOG2);
        pipe_d[0].hsync_on = hsync_on;
        pipe_d[0].vsync_on = vsync_on;
        pipe_d[0].sof      = sof;
        pipe_d[0].mode     = mode_d;
        pipe_d[0].bar      = 3'd7 - bar_idx_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        tail  = pipe_q[RD_LATENCY-1];
        rgb_d = '0;
        if (tail.active) begin
            case (tail.mode)
                MODE_BITMAP: rgb_d = tail.in_image ? mem.mem_data : border_rgb;
                MODE_BARS:   rgb_d = {{BPC{tail.bar[2]}}, {BPC{tail.bar[1]}}, {BPC{tail.bar[0]}}};
                MODE_BORDER: rgb_d = border_rgb;
                default:     rgb_d = '0;
            endcase
        end
        hsync_d = tail.hsync_on ? SYNC_POL : !SYNC_POL;
        vsync_d = tail.vsync_on ? SYNC_POL : !SYNC_POL;
        fs_d    = tail.sof;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q <= '0;
            bar_px_q   <= '0;
            bar_idx_q  <= '0;
            mode_q     <= MODE_BITMAP;
            pipe_q     <= '0;
            rgb_q      <= '0;
            hsync_q    <= !SYNC_POL;
            vsync_q    <= !SYNC_POL;
            fs_q       <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            bar_px_q   <= bar_px_d;
            bar_idx_q  <= bar_idx_d;
            mode_q     <= mode_d;
            pipe_q     <= pipe_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            fs_q       <= fs_d;
        end
    end

    assign mem.mem_addr           = mem_addr_q;
    assign {vga_r, vga_g, vga_b}  = rgb_q;
    assign vga_hsync              = hsync_q;
    assign vga_vsync              = vsync_q;
    assign frame_start            = fs_q;

endmodule

// File: tb/tb_vga_bitmap_scanout.sv
// Bench for vga_bitmap_scanout on a reduced 80x48 raster: two instances
// (latency 1 / active-low syncs, latency 3 / 2x scale / active-high syncs).
module tb_vga_bitmap_scanout;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int IMG_LOG2 = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd3;
    logic [8:0] border_rgb = 9'h1C0;

    always #5 clk = ~clk;

    vga_bitmap_scanout_if #(.ADDR_W(10), .DATA_W(9)) mem_a ();
    vga_bitmap_scanout_if #(.ADDR_W(10), .DATA_W(9)) mem_b ();

    logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;
    logic [11:0] got_a, got_b;

    assign got_a = {a_r, a_g, a_b, a_hs, a_vs, a_fs};
    assign got_b = {b_r, b_g, b_b, b_hs, b_vs, b_fs};

    vga_bitmap_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .BPC(3), .IMG_W_LOG2(IMG_LOG2), .IMG_H_LOG2(IMG_LOG2),
        .SCALE_LOG2(0), .RD_LATENCY(1)
    ) dut_a (
        .clk(clk), .reset(reset), .mode(mode), .border_rgb(border_rgb), .mem(mem_a),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .frame_start(a_fs)
    );

    vga_bitmap_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b1), .BPC(3), .IMG_W_LOG2(IMG_LOG2), .IMG_H_LOG2(IMG_LOG2),
        .SCALE_LOG2(1), .RD_LATENCY(3)
    ) dut_b (
        .clk(clk), .reset(reset), .mode(mode), .border_rgb(border_rgb), .mem(mem_b),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .frame_start(b_fs)
    );

    // Synchronous memories returning address[8:0] after 1 and 3 clocks.
    logic [8:0] lat_a = '0;
    logic [8:0] lat_b [3] = '{default: '0};

    always @(posedge clk) begin
        lat_a    <= mem_a.mem_addr[8:0];
        lat_b[0] <= mem_b.mem_addr[8:0];
        lat_b[1] <= lat_b[0];
        lat_b[2] <= lat_b[1];
    end

    assign mem_a.mem_data = lat_a;
    assign mem_b.mem_data = lat_b[2];

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;
    int epoch    = 0;
    bit in_reset = 1'b0;
    int frame_mode [16] = '{default: 0};
    bit seen_fs_a, seen_fs_b;
    int hrun_a, vrun_a, hrun_b, vrun_b;

    typedef struct {
        int ep;
        int dut;
        int f;
        int x;
        int y;
        logic [8:0] rgb;
    } lit_t;

    lit_t lits [16] = '{
        '{1, 0, 0,  5,  2, 9'h000},
        '{1, 0, 1,  0,  5, 9'h1FF},
        '{1, 0, 1,  8,  5, 9'h1F8},
        '{1, 0, 1, 60,  5, 9'h000},
        '{1, 0, 1, 70,  5, 9'h000},
        '{1, 0, 2,  5,  2, 9'h045},
        '{1, 0, 2, 40, 10, 9'h1C0},
        '{1, 0, 3,  5, 20, 9'h085},
        '{1, 0, 4,  5,  2, 9'h1C0},
        '{1, 1, 2,  0,  0, 9'h000},
        '{1, 1, 2,  1,  0, 9'h000},
        '{1, 1, 2,  0,  1, 9'h000},
        '{1, 1, 2,  1,  1, 9'h000},
        '{1, 1, 2,  2,  0, 9'h001},
        '{1, 1, 2,  5,  3, 9'h022},
        '{2, 0, 0,  5,  2, 9'h045}
    };

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (epoch %0d, cycle %0d)", name, act, exp, epoch, n);
        end
    endtask

    // What the pins must show for raster position p (clocks since pixel (0,0)
    // of the first frame after reset); negative p means still inside the pipeline.
    function automatic logic [11:0] model(int p, int s, bit pol);
        int h, v, x, y, md, i;
        logic [8:0] rgb;
        bit hs, vs, fs;
        if (p < 0) return {9'h000, ~pol, ~pol, 1'b0};
        h  = p % HT;
        v  = (p / HT) % VT;
        md = frame_mode[(p / FT) % 16];
        hs = (h >= HA + HFP) && (h < HA + HFP + HS);
        vs = (v >= VA + VFP) && (v < VA + VFP + VS);
        fs = (h == 0) && (v == 0);
        rgb = '0;
        if (h < HA && v < VA) begin
            case (md)
                0: begin
                    x = h >> s;
                    y = v >> s;
                    if (x < 32 && y < 32) rgb = 9'((y * 32 + x) % 512);
                    else                  rgb = border_rgb;
                end
                1: begin
                    i   = 7 - h / (HA / 8);
                    rgb = {{3{i[2]}}, {3{i[1]}}, {3{i[0]}}};
                end
                2: rgb = border_rgb;
                default: rgb = '0;
            endcase
        end
        return {rgb, hs ? pol : ~pol, vs ? pol : ~pol, fs};
    endfunction

    always @(negedge clk) begin
        int p;
        if (reset) begin
            if (!in_reset) epoch++;
            in_reset  = 1'b1;
            n         = 0;
            seen_fs_a = 1'b0;
            seen_fs_b = 1'b0;
            hrun_a = 0; vrun_a = 0; hrun_b = 0; vrun_b = 0;
            check_output("reset_a", 32'(got_a), 32'h006);
            check_output("reset_b", 32'(got_b), 32'h000);
        end else begin
            in_reset = 1'b0;
            if (n % FT == 0) frame_mode[(n / FT) % 16] = int'(mode);

            check_output("pins_a", 32'(got_a), 32'(model(n - 2, 0, 1'b0)));
            check_output("pins_b", 32'(got_b), 32'(model(n - 4, 1, 1'b1)));

            for (int k = 0; k < 16; k++) begin
                p = (lits[k].dut == 0) ? n - 2 : n - 4;
                if (lits[k].ep == epoch && p == lits[k].f * FT + lits[k].y * HT + lits[k].x)
                    check_output($sformatf("lit%0d", k),
                                 32'((lits[k].dut == 0) ? got_a[11:3] : got_b[11:3]),
                                 32'(lits[k].rgb));
            end

            if (a_fs && !seen_fs_a) begin
                check_output("first_fs_a", n, 2);
                seen_fs_a = 1'b1;
            end
            if (b_fs && !seen_fs_b) begin
                check_output("first_fs_b", n, 4);
                seen_fs_b = 1'b1;
            end

            if (!a_hs) hrun_a++;
            else if (hrun_a > 0) begin check_output("hsync_width_a", hrun_a, HS); hrun_a = 0; end
            if (!a_vs) vrun_a++;
            else if (vrun_a > 0) begin check_output("vsync_width_a", vrun_a, VS * HT); vrun_a = 0; end
            if (b_hs) hrun_b++;
            else if (hrun_b > 0) begin check_output("hsync_width_b", hrun_b, HS); hrun_b = 0; end
            if (b_vs) vrun_b++;
            else if (vrun_b > 0) begin check_output("vsync_width_b", vrun_b, VS * HT); vrun_b = 0; end

            n++;
        end
    end

    task automatic apply_stimulus(input int clocks);
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        mode       = 2'd3;
        border_rgb = 9'h1C0;
        apply_stimulus(3);
        reset = 1'b0;
        apply_stimulus(FT / 2);
        mode = 2'd1;
        apply_stimulus(FT);
        mode = 2'd0;
        apply_stimulus(FT + FT / 2 + 10 * HT);
        mode = 2'd2;
        apply_stimulus(2 * FT + 10 * HT + 40);
        reset = 1'b1;
        mode  = 2'd0;
        apply_stimulus(3);
        reset = 1'b0;
        apply_stimulus(FT + FT / 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_bitmap_scanout.md
# vga_bitmap_scanout

Parametrised VGA scan-out engine for the pixel-clock domain: generates horizontal/vertical timing, drives the read address of an external synchronous bitmap memory, and re-aligns syncs with the memory's read latency. Each output pixel comes from the bitmap, a border colour, a built-in colour-bar pattern, or black. It sits between the pixel PLL output and the board's VGA DAC pins, replacing ad-hoc timing, ROM addressing and colour-register glue in top-level designs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 0, sync asserted level (0 = active-low)
- BPC, 3, bits per colour channel
- IMG_W_LOG2 / IMG_H_LOG2, 8 / 8, bitmap dimensions as log2 of source pixels
- SCALE_LOG2, 0, each bitmap pixel replicated 2^SCALE_LOG2 times in x and y
- RD_LATENCY, 1, memory clocks from address to data; range 1..4
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- mode  in  2  0 bitmap, 1 colour bars, 2 solid border, 3 black
- border_rgb  in  3*BPC  {R,G,B} colour used outside the bitmap and in mode 2
- mem_addr  out  IMG_H_LOG2+IMG_W_LOG2  {y,x} bitmap address
- mem_data  in  3*BPC  {R,G,B} read data, valid RD_LATENCY clocks after mem_addr
- vga_r / vga_g / vga_b  out  BPC each  registered colour
- vga_hsync / vga_vsync  out  1  registered syncs at SYNC_POL
- frame_start  out  1  one-clock pulse coincident with pixel (0,0) at the pins

## Operation
- hcount 0..H_TOTAL-1 (H_TOTAL = sum of H params); wraps to 0, increments vcount; vcount wraps at V_TOTAL-1.
- Active: hcount < H_ACTIVE and vcount < V_ACTIVE. hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vcount.
- Source coordinates: x = hcount >> SCALE_LOG2, y = vcount >> SCALE_LOG2. In-image when x < 2^IMG_W_LOG2 and y < 2^IMG_H_LOG2; mem_addr = {y[IMG_H_LOG2-1:0], x[IMG_W_LOG2-1:0]}, registered from the counters; held at 0 outside in-image.
- Pixel select at output stage: blanking → 0; mode 0 → mem_data if in-image, else border_rgb; mode 1 → bar colour; mode 2 → border_rgb; mode 3 → 0.
- Colour bars: bar index b = 0..7 advances every H_ACTIVE/8 active pixels (dedicated counter, no divider); i = 7-b; colour = {{BPC{i[2]}},{BPC{i[1]}},{BPC{i[0]}}} (white first, black last).
- mode is sampled only when hcount = 0 and vcount = 0; mid-frame changes take effect at the next frame.
- border_rgb is used combinationally at the output stage; no sampling.

## Timing
- Counter-to-pin latency is exactly RD_LATENCY+1 clocks for colour, syncs and frame_start; active, in-image, sync and mode flags travel a RD_LATENCY-deep shift register beside the memory access.
- Reset (async assert, sync release): counters 0, delay line cleared, mem_addr 0, rgb 0, syncs at !SYNC_POL, frame_start 0. The first frame_start follows RD_LATENCY+1 clocks after release.
- Reset mid-frame: outputs go inactive immediately; no partial sync pulse beyond the reset assertion.
- Image larger than active area: cropped. Smaller: right and bottom filled with border_rgb.

## Structure
- Shared package vga_pkg: timing defaults, H_TOTAL/V_TOTAL functions, mode encoding constants (MODE_BITMAP, MODE_BARS, MODE_BORDER, MODE_BLACK).
- Sub-module vga_timing: counters, active/sync flags, start-of-frame strobe; reusable by other display blocks.

## Test plan
- Defaults, mode 3, run 2 frames → hsync low exactly 96 clocks per 800-clock line; vsync low 2 lines of 525; rgb always 0.
- Mode 0, RD_LATENCY=1, model memory returns data = address[8:0] → pixel (5,2) at pins shows {R,G,B} = 9'h205 & 9'h1FF; pixel (300,10) shows border_rgb = 9'h1C0.
- RD_LATENCY=3, SCALE_LOG2=1 → pixels (0,0),(1,0),(0,1),(1,1) carry address 0; (2,0) carries address 1; syncs shift in step with colour.
- Mode 1 → active pixels 0..79 all-ones, 80..159 {7,7,0}, 560..639 black; blanking 0.
- Mode switched 0→2 at line 100 → change visible only after next frame_start.
- Reset asserted at hcount 400, vcount 200 for 3 clocks → outputs inactive within the same clock; frame_start returns 2 clocks after release; full frame timing thereafter.
